// File: rtl/sar_conv_ctrl_if.sv
// Downstream valid/ready sample stream between sar_conv_ctrl and the digital back end.
interface sar_conv_ctrl_if;
    logic [7:0] dout_data;
    logic       dout_valid;
    logic       dout_ready;

    modport master (output dout_data, output dout_valid, input dout_ready);
    modport slave  (input dout_data, input dout_valid, output dout_ready);
endinterface

// File: rtl/sar_conv_ctrl.sv
// Host-side initiator for the 8-bit SAR ADC core: paced cnvst pulses, eoc timeout,
// show-ahead sample FIFO and sticky overflow/timeout flags.
module sar_conv_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 63,
    parameter int PER_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PER_W-1:0] period,
    input  logic             eoc,
    input  logic [7:0]       sar,
    output logic             cnvst,
    output logic             busy,
    output logic             overflow,
    output logic             timeout_err,
    input  logic             err_clr,
    sar_conv_ctrl_if.master  dout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_EOC, HOLDOFF} state_t;

    state_t           state, state_next;
    logic [PER_W-1:0] per_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             push, to_hit;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, pop, push_ok;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        push       = 1'b0;
        to_hit     = 1'b0;
        case (state)
            IDLE:     if (en) state_next = START;
            START:    state_next = WAIT_EOC;
            WAIT_EOC: begin
                if (eoc) begin
                    push       = 1'b1;
                    state_next = HOLDOFF;
                end else if (to_cnt == TO_W'(TIMEOUT)) begin
                    to_hit     = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF:  if (per_cnt == '0) state_next = en ? START : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // The hold-off count is period-2: START and the last HOLDOFF cycle complete the interval.
    always_ff @(posedge clk) begin
        // NOTE: rst is synchronous, so it is only a priority branch inside the clocked block.
        if (rst) begin
            state   <= IDLE;
            cnvst   <= 1'b0;
            busy    <= 1'b0;
            per_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            state <= state_next;
            cnvst <= (state_next == START);
            busy  <= (state_next != IDLE);
            if (state == START) begin
                per_cnt <= (period > PER_W'(2)) ? period - PER_W'(2) : '0;
                to_cnt  <= '0;
            end else begin
                if (per_cnt != '0) per_cnt <= per_cnt - PER_W'(1);
                if (state == WAIT_EOC) to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    assign dout.dout_valid = (count != '0);
    assign dout.dout_data  = mem[rd_ptr];
    assign pop             = dout.dout_valid && dout.dout_ready;
    assign full            = (count == CNT_W'(FIFO_DEPTH));
    assign push_ok         = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is cleared too, so dout_data reads 0 straight out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= sar;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A set event in the same cycle as err_clr keeps the flag high.
            overflow    <= (push && full && !pop) || (overflow && !err_clr);
            timeout_err <= to_hit || (timeout_err && !err_clr);
        end
    end
endmodule
